// File: rtl/m_ext_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : m_ext_pkg
//  Description : Shared types and widths for the RV32M execute-stage blocks.
//  Revision    : 1.0  initial release
// ============================================================================
package m_ext_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One combinational radix-2 restoring-division iteration.
//  Revision    : 1.0  initial release
// ============================================================================
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] w_shifted;
    logic [XLEN:0] w_diff;

    // The shifted remainder is below 2*divisor, so the difference always fits
    // in XLEN+1 bits and its top bit is a true sign.
    assign w_shifted = {rem, quo[XLEN-1]};
    assign w_diff    = w_shifted - {1'b0, divisor};

    always_comb begin
        if (!w_diff[XLEN]) begin
            rem_next = w_diff[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_next = w_shifted[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b0};
        end
    end

endmodule
`default_nettype wire

// File: rtl/divider_iterative.sv
`default_nettype none
// ============================================================================
//  Module      : divider_iterative
//  Description : Multi-cycle RV32M DIV/DIVU/REM/REMU unit, startE/done handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module divider_iterative
    import m_ext_pkg::*;
#(
    parameter int XLEN  = m_ext_pkg::XLEN,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            startE,
    input  logic [1:0]      div_opcode,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    output logic [XLEN-1:0] result_divide,
    output logic            done,
    output logic            busy
);

    localparam logic [XLEN-1:0]  C_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] C_CNT_TOP = CNT_W'(XLEN - 1);

    div_state_e      state_q,   state_d;
    div_op_e         op_q,      op_d;
    logic            quo_neg_q, quo_neg_d;
    logic            rem_neg_q, rem_neg_d;
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic [XLEN-1:0] rem_q,     rem_d;
    logic [XLEN-1:0] quo_q,     quo_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [XLEN-1:0] result_q,  result_d;

    logic            w_signed;
    logic            w_sign1;
    logic            w_sign2;
    logic [XLEN-1:0] w_abs1;
    logic [XLEN-1:0] w_abs2;
    logic [XLEN-1:0] w_rem_step;
    logic [XLEN-1:0] w_quo_step;
    logic [XLEN-1:0] w_q_fixed;
    logic [XLEN-1:0] w_r_fixed;

    assign w_signed = ~div_opcode[0];
    assign w_sign1  = w_signed & operand1[XLEN-1];
    assign w_sign2  = w_signed & operand2[XLEN-1];
    assign w_abs1   = w_sign1 ? (~operand1 + 1'b1) : operand1;
    assign w_abs2   = w_sign2 ? (~operand2 + 1'b1) : operand2;

    assign w_q_fixed = quo_neg_q ? (~quo_q + 1'b1) : quo_q;
    assign w_r_fixed = rem_neg_q ? (~rem_q + 1'b1) : rem_q;

    div_step #(
        .XLEN (XLEN)
    ) u_div_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (divisor_q),
        .rem_next (w_rem_step),
        .quo_next (w_quo_step)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        result_d  = result_q;

        case (state_q)
            IDLE: begin
                if (startE) begin
                    op_d = div_op_e'(div_opcode);
                    if (operand2 == '0) begin
                        result_d = div_opcode[1] ? operand1 : '1;
                        state_d  = DONE;
                    end else if (w_signed && operand1 == C_MIN_NEG && operand2 == '1) begin
                        result_d = div_opcode[1] ? '0 : C_MIN_NEG;
                        state_d  = DONE;
                    end else begin
                        divisor_d = w_abs2;
                        quo_d     = w_abs1;
                        rem_d     = '0;
                        quo_neg_d = w_sign1 ^ w_sign2;
                        rem_neg_d = w_sign1;
                        cnt_d     = C_CNT_TOP;
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = w_rem_step;
                quo_d = w_quo_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = op_q[1] ? w_r_fixed : w_q_fixed;
                state_d  = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= DIV;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
        end
    end

    assign result_divide = result_q;
    assign done          = (state_q == DONE);
    assign busy          = (state_q == CALC) || (state_q == FIX);

endmodule
`default_nettype wire
